// File: rtl/top_pkg.sv
// Shared constants and types for the windowed sample accumulator.
package top_pkg;

    localparam int SUM_W    = 14;
    localparam int CNT_W    = 7;
    localparam int PEAK_W   = 8;
    localparam int PEAK_LSB = 24;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/top_window_ctrl.sv
// Window sequencing for top_window_accum: length latch, sample count,
// busy/done flags, plus same-cycle start/complete strobes for the datapath.
module top_window_ctrl
    import top_pkg::*;
#(
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic [LEN_W-1:0] z,
    output logic             start,
    output logic             complete,
    output logic             busy,
    output logic             done
);

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   len_r;
    logic               busy_r;
    logic               done_r;

    logic [CNT_W-1:0]   z_len_s;
    logic [CNT_W-1:0]   len_eff_s;
    logic [CNT_W-1:0]   next_count_s;
    logic               start_s;
    logic               complete_s;

    // Decode the window length and the strobes for the current accept edge
    always_comb begin
        z_len_s      = (z == {LEN_W{1'b0}}) ? 7'd64 : CNT_W'(z);
        // The first sample of a window must see Z directly, since len_r is only loaded on that edge
        len_eff_s    = (state_r == IDLE) ? z_len_s : len_r;
        next_count_s = count_r + 7'd1;
        start_s      = x && (state_r == IDLE);
        complete_s   = x && (next_count_s == len_eff_s);
    end

    // Window FSM with count, latched length and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= 7'd0;
            len_r   <= 7'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (x) begin
            if (start_s) begin
                len_r <= z_len_s;
            end else begin
                len_r <= len_r;
            end
            case (complete_s)
                1'b1: begin
                    state_r <= IDLE;
                    count_r <= 7'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ACCUM;
                    count_r <= next_count_s;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end else begin
            done_r <= 1'b0;
        end
    end

    assign start    = start_s;
    assign complete = complete_s;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: rtl/top_window_accum.sv
// Windowed sample accumulator: sums Z accepted samples and publishes the total on A.
// Optional build macro TOP_PEAK_EN adds the window peak sample in A[31:24].
module top_window_accum
    import top_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              X,
    input  logic [DATA_W-1:0] Y,
    input  logic [LEN_W-1:0]  Z,
    output logic [OUT_W-1:0]  A,
    output logic              B,
    output logic              C
);

    logic               start_s;
    logic               complete_s;
    logic               busy_s;
    logic               done_s;

    logic [SUM_W-1:0]   sum_r;
    logic [SUM_W-1:0]   next_sum_s;
    logic [OUT_W-1:0]   a_r;
    logic [OUT_W-1:0]   a_next_s;

    top_window_ctrl #(
        .LEN_W    (LEN_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .x        (X),
        .z        (Z),
        .start    (start_s),
        .complete (complete_s),
        .busy     (busy_s),
        .done     (done_s)
    );

`ifdef TOP_PEAK_EN
    logic [PEAK_W-1:0]  peak_r;
    logic [PEAK_W-1:0]  next_peak_s;

    // Running maximum; a new window starts from the incoming sample alone
    always_comb begin
        if (start_s || (Y > peak_r)) begin
            next_peak_s = Y;
        end else begin
            next_peak_s = peak_r;
        end
    end

    // Peak register, cleared once its window has been published
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_r <= 8'd0;
        end else if (X) begin
            peak_r <= complete_s ? 8'd0 : next_peak_s;
        end else begin
            peak_r <= peak_r;
        end
    end
`endif

    // Sum of the current window including the sample being accepted, and the A word built from it
    always_comb begin
        next_sum_s = sum_r + SUM_W'(Y);
        a_next_s   = {OUT_W{1'b0}};
        a_next_s[SUM_W-1:0] = next_sum_s;
`ifdef TOP_PEAK_EN
        a_next_s[PEAK_LSB +: PEAK_W] = next_peak_s;
`endif
    end

    // Sum accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 14'd0;
            a_r   <= 32'd0;
        end else if (X && complete_s) begin
            sum_r <= 14'd0;
            a_r   <= a_next_s;
        end else if (X) begin
            sum_r <= next_sum_s;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign A = a_r;
    assign B = busy_s;
    assign C = done_s;

endmodule

// File: tb/tb_top_window_accum.sv
// Directed self-checking bench for top_window_accum (either TOP_PEAK_EN build).
`timescale 1ns/1ps
module tb_top_window_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        X   = 1'b0;
    logic [7:0]  Y   = 8'd0;
    logic [5:0]  Z   = 6'd0;
    logic [31:0] A;
    logic        B;
    logic        C;

    int checks = 0;
    int errors = 0;

    top_window_accum dut (
        .clk (clk),
        .rst (rst),
        .X   (X),
        .Y   (Y),
        .Z   (Z),
        .A   (A),
        .B   (B),
        .C   (C)
    );

    always #5 clk = ~clk;

    // Expected A for a completed window with the given sum and peak sample
    function automatic logic [31:0] exp_a(input int sum, input int peak);
`ifdef TOP_PEAK_EN
        return (32'(peak) << 24) | 32'(sum);
`else
        return 32'(sum) + 32'd0 * 32'(peak);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] y);
        X = 1'b1;
        Y = y;
        step();
    endtask

    task automatic idle();
        X = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; X = 1'b1; Y = 8'd77; Z = 6'd2;
        step(); step();
        checks++;
        if ({A, B, C} !== {32'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_state A=%0d B=%0b C=%0b want A=0 B=0 C=0", A, B, C);
        end
        rst = 1'b0;
        Z = 6'd1;
        accept(8'd9);
        checks++;
        if ({A, C} !== {exp_a(9, 9), 1'b1}) begin
            errors++; $display("FAIL reset_pre_window A=%h C=%0b want A=%h C=1", A, C, exp_a(9, 9));
        end
        Z = 6'd4;
        accept(8'd50); accept(8'd60); accept(8'd70);
        rst = 1'b1; X = 1'b0;
        step();
        checks++;
        if ({A, B, C} !== {32'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_mid_window A=%0d B=%0b C=%0b want A=0 B=0 C=0", A, B, C);
        end
        rst = 1'b0;
        Z = 6'd2;
        accept(8'd1); accept(8'd2);
        checks++;
        if ({A, C} !== {exp_a(3, 2), 1'b1}) begin
            errors++; $display("FAIL reset_fresh_sum A=%h C=%0b want A=%h C=1", A, C, exp_a(3, 2));
        end
        idle();
    endtask

    task automatic test_basic();
        Z = 6'd4;
        accept(8'd10);
        checks++;
        if ({B, C} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL basic_busy B=%0b C=%0b want B=1 C=0", B, C);
        end
        accept(8'd20); accept(8'd30); accept(8'd40);
        checks++;
        if ({A, B, C} !== {exp_a(100, 40), 1'b0, 1'b1}) begin
            errors++; $display("FAIL basic_done A=%h B=%0b C=%0b want A=%h B=0 C=1", A, B, C, exp_a(100, 40));
        end
        idle(); idle();
        checks++;
        if ({A, B, C} !== {exp_a(100, 40), 1'b0, 1'b0}) begin
            errors++; $display("FAIL basic_hold A=%h B=%0b C=%0b want A=%h B=0 C=0", A, B, C, exp_a(100, 40));
        end
    endtask

    task automatic test_full_window();
        Z = 6'd0;
        for (int i = 0; i < 63; i++) accept(8'd255);
        checks++;
        if ({B, C} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL full_63 B=%0b C=%0b want B=1 C=0", B, C);
        end
        accept(8'd255);
        checks++;
        if ({A, B, C} !== {exp_a(16320, 255), 1'b0, 1'b1}) begin
            errors++; $display("FAIL full_64 A=%h B=%0b C=%0b want A=%h B=0 C=1", A, B, C, exp_a(16320, 255));
        end
        idle();
        checks++;
        if (C !== 1'b0) begin
            errors++; $display("FAIL full_single_pulse C=%0b want 0", C);
        end
    endtask

    task automatic test_len1();
        Z = 6'd1;
        for (int i = 1; i <= 3; i++) begin
            accept(8'(i));
            checks++;
            if ({A, B, C} !== {exp_a(i, i), 1'b0, 1'b1}) begin
                errors++; $display("FAIL len1_%0d A=%h B=%0b C=%0b want A=%h B=0 C=1", i, A, B, C, exp_a(i, i));
            end
        end
        idle();
    endtask

    task automatic test_gapped();
        Z = 6'd3;
        accept(8'd5);
        Z = 6'd10;
        idle(); idle();
        checks++;
        if ({B, C} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL gap_hold B=%0b C=%0b want B=1 C=0", B, C);
        end
        accept(8'd9);
        idle();
        accept(8'd7);
        checks++;
        if ({A, B, C} !== {exp_a(21, 9), 1'b0, 1'b1}) begin
            errors++; $display("FAIL gap_done A=%h B=%0b C=%0b want A=%h B=0 C=1", A, B, C, exp_a(21, 9));
        end
        idle();
    endtask

    task automatic test_back_to_back();
        Z = 6'd2;
        accept(8'd3); accept(8'd4);
        checks++;
        if ({A, C} !== {exp_a(7, 4), 1'b1}) begin
            errors++; $display("FAIL b2b_first A=%h C=%0b want A=%h C=1", A, C, exp_a(7, 4));
        end
        accept(8'd6);
        checks++;
        if ({A, B, C} !== {exp_a(7, 4), 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_restart A=%h B=%0b C=%0b want A=%h B=1 C=0", A, B, C, exp_a(7, 4));
        end
        accept(8'd1);
        checks++;
        if ({A, B, C} !== {exp_a(7, 6), 1'b0, 1'b1}) begin
            errors++; $display("FAIL b2b_second A=%h B=%0b C=%0b want A=%h B=0 C=1", A, B, C, exp_a(7, 6));
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_window();
        test_len1();
        test_gapped();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
